// File: rtl/conv_scheduler_if.sv
// Operand/result handshake bundle between requesters, consumer and the scheduler.
interface conv_scheduler_if #(
   parameter int WIDTH = 6,
   parameter int RES_W = 4
);
   logic             req0_valid;
   logic             req1_valid;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             req0_ready;
   logic             req1_ready;
   logic             res_valid;
   logic [RES_W-1:0] res_data;
   logic             res_id;
   logic             res_ready;
   logic             busy;

   modport slave (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, res_ready,
      output req0_ready, req1_ready, res_valid, res_data, res_id, busy
   );

   modport master (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, res_ready,
      input  req0_ready, req1_ready, res_valid, res_data, res_id, busy
   );
endinterface

// File: rtl/conv_scheduler.sv
// Two-requester bit-serial popcount(a & b) engine with alternating-priority grant.
//
// state | meaning
// IDLE  | waiting for a request; grant and ready are combinational
// RUN   | shifting one operand bit pair into the accumulator per edge
// DONE  | result presented, held until the consumer takes it
module conv_scheduler #(
   parameter int WIDTH = 6,
   parameter int RES_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   conv_scheduler_if.slave   bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sa_q, sb_q;
   logic [RES_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [RES_W-1:0]   res_q;
   logic               res_id_q;
   logic               id_q;
   logic               last_q;
   logic               gnt_vld, gnt_id;
   logic               accept, last_bit;
   logic               ready0, ready1, res_valid, busy;

   always_comb begin
      gnt_vld = bus.req0_valid | bus.req1_valid;
      // under contention the requester not served last wins
      gnt_id  = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
   end

   assign last_bit = (cnt_q == CNT_W'(WIDTH-1));
   assign acc_d    = acc_q + {{(RES_W-1){1'b0}}, (sa_q[0] & sb_q[0])};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      ready0    = 1'b0;
      ready1    = 1'b0;
      accept    = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b1;
      case (state_q)
         IDLE: begin
            busy   = 1'b0;
            // gated by reset so no ready is shown while the block is held
            ready0 = reset & gnt_vld & ~gnt_id;
            ready1 = reset & gnt_vld & gnt_id;
            accept = gnt_vld;
            if (accept) state_d = RUN;
         end
         RUN: begin
            if (last_bit) state_d = DONE;
         end
         DONE: begin
            res_valid = 1'b1;
            if (bus.res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sa_q     <= '0;
         sb_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         res_q    <= '0;
         res_id_q <= 1'b0;
         id_q     <= 1'b0;
         last_q   <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  sa_q   <= gnt_id ? bus.req1_a : bus.req0_a;
                  sb_q   <= gnt_id ? bus.req1_b : bus.req0_b;
                  acc_q  <= '0;
                  cnt_q  <= '0;
                  id_q   <= gnt_id;
                  last_q <= gnt_id;
               end
            end
            RUN: begin
               acc_q <= acc_d;
               sa_q  <= sa_q >> 1;
               sb_q  <= sb_q >> 1;
               cnt_q <= cnt_q + CNT_W'(1);
               // separate result register keeps res_data stable across the next run
               if (last_bit) begin
                  res_q    <= acc_d;
                  res_id_q <= id_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.res_valid  = res_valid;
   assign bus.res_data   = res_q;
   assign bus.res_id     = res_id_q;
   assign bus.busy       = busy;
endmodule

// File: tb/tb_conv_scheduler.sv
// Directed bench for conv_scheduler: reset, latency, boundaries, fairness, backpressure, mid-run reset.
module tb_conv_scheduler;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;

   conv_scheduler_if #(.WIDTH(6), .RES_W(4)) bus ();

   conv_scheduler #(.WIDTH(6), .RES_W(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input logic id, input logic [5:0] a, input logic [5:0] b,
                        input logic [3:0] exp, input string tag);
      int n;
      if (id == 1'b0) begin
         bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
      end else begin
         bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
      end
      bus.res_ready = 1'b1;
      #1;
      chk({tag, "_rdy"}, id ? bus.req1_ready : bus.req0_ready, 1);
      step();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      chk({tag, "_busy"}, bus.busy, 1);
      n = 0;
      while (!bus.res_valid && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_lat"}, n, 6);
      chk({tag, "_data"}, bus.res_data, exp);
      chk({tag, "_id"}, bus.res_id, id);
      step();
      chk({tag, "_vld_lo"}, bus.res_valid, 0);
      chk({tag, "_hold"}, bus.res_data, exp);
   endtask

   initial begin
      int  n;
      logic seen;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b0;
      bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_a = '0; bus.req1_b = '0;
      bus.res_ready = 1'b1;

      // reset state, including readys gated while a request is pending
      step();
      chk("rst_vld", bus.res_valid, 0);
      chk("rst_data", bus.res_data, 0);
      chk("rst_id", bus.res_id, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_rdy0", bus.req0_ready, 0);
      chk("rst_rdy1", bus.req1_ready, 0);
      reset = 1'b1;

      do_op(1'b0, 6'b111111, 6'b101010, 4'd3, "single");
      do_op(1'b1, 6'b000000, 6'b111111, 4'd0, "zero_a");
      do_op(1'b0, 6'b010101, 6'b101010, 4'd0, "alt");
      do_op(1'b1, 6'b000001, 6'b000001, 4'd1, "lsb");

      // contention from reset release, then fairness over four operations
      reset = 1'b0;
      step();
      bus.req0_valid = 1'b1; bus.req0_a = 6'b111111; bus.req0_b = 6'b111111;
      bus.req1_valid = 1'b1; bus.req1_a = 6'b111111; bus.req1_b = 6'b111111;
      #1;
      chk("cont_rst_rdy0", bus.req0_ready, 0);
      reset = 1'b1;
      #1;
      chk("cont_rdy0", bus.req0_ready, 1);
      chk("cont_rdy1", bus.req1_ready, 0);
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!bus.res_valid && n < 20) begin
            chk("cont_onehot", {31'd0, bus.req0_ready & bus.req1_ready}, 0);
            step();
            n++;
         end
         chk("fair_id", bus.res_id, i % 2);
         chk("fair_data", bus.res_data, 6);
         step();
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;

      // backpressure in DONE while another request waits
      bus.res_ready = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_a = 6'b110011; bus.req1_b = 6'b111111;
      step();
      bus.req1_valid = 1'b0;
      n = 0;
      while (!bus.res_valid && n < 20) begin
         step();
         n++;
      end
      chk("bp_lat", n, 6);
      bus.req0_valid = 1'b1; bus.req0_a = 6'b000001; bus.req0_b = 6'b000001;
      for (int i = 0; i < 5; i++) begin
         chk("bp_vld", bus.res_valid, 1);
         chk("bp_data", bus.res_data, 4);
         chk("bp_id", bus.res_id, 1);
         chk("bp_busy", bus.busy, 1);
         chk("bp_rdy0", bus.req0_ready, 0);
         chk("bp_rdy1", bus.req1_ready, 0);
         step();
      end
      bus.res_ready = 1'b1;
      step();
      chk("bp_done_vld", bus.res_valid, 0);
      chk("bp_done_busy", bus.busy, 0);
      chk("bp_done_data", bus.res_data, 4);
      chk("bp_next_rdy0", bus.req0_ready, 1);
      step();
      bus.req0_valid = 1'b0;
      n = 0;
      while (!bus.res_valid && n < 20) begin
         step();
         n++;
      end
      chk("bp_next_lat", n, 6);
      chk("bp_next_data", bus.res_data, 1);
      chk("bp_next_id", bus.res_id, 0);
      step();

      // reset pulse in the middle of a run discards the operation
      bus.req1_valid = 1'b1; bus.req1_a = 6'b111111; bus.req1_b = 6'b111111;
      step();
      bus.req1_valid = 1'b0;
      step();
      step();
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_vld", bus.res_valid, 0);
      chk("mid_rst_data", bus.res_data, 0);
      chk("mid_rst_id", bus.res_id, 0);
      chk("mid_rst_rdy1", bus.req1_ready, 0);
      step();
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         seen = seen | bus.res_valid;
         step();
      end
      chk("mid_rst_no_res", seen, 0);
      do_op(1'b0, 6'b111111, 6'b001111, 4'd4, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
